// File: rtl/nco_dll.sv
// nco_dll: phase-accumulator NCO producing square, quadrature and wrap outputs,
// plus an accumulate-and-dump decimator that turns the frequency word into a pitch sample.
module nco_dll #(
  parameter int FREQ_W  = 8,
  parameter int PHASE_W = 12,
  parameter int DEC_W   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FREQ_W-1:0]       freq_i,
  output logic                    sq_o,
  output logic                    sq90_o,
  output logic                    cyc_o,
  output logic [FREQ_W+DEC_W-1:0] pitch_o,
  output logic                    pitch_vld_o
);

  localparam int SUM_W = FREQ_W + DEC_W;

  logic [FREQ_W-1:0]  freq_r;
  logic [PHASE_W-1:0] acc_r;
  logic [PHASE_W:0]   acc_sum_s;
  logic [DEC_W-1:0]   dec_cnt_r;
  logic [SUM_W-1:0]   sum_r;
  logic [SUM_W-1:0]   sum_nxt_s;
  logic               dec_tc_s;

  // Next phase (with carry) and next decimator sum
  always_comb begin
    acc_sum_s = {1'b0, acc_r} + {{(PHASE_W+1-FREQ_W){1'b0}}, freq_r};
    sum_nxt_s = sum_r + {{DEC_W{1'b0}}, freq_r};
    dec_tc_s  = (dec_cnt_r == {DEC_W{1'b1}});
  end

  // Input register, phase accumulator and outputs derived from the next phase
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      freq_r <= '0;
      acc_r  <= '0;
      sq_o   <= 1'b0;
      sq90_o <= 1'b0;
      cyc_o  <= 1'b0;
    end else begin
      freq_r <= freq_i;
      acc_r  <= acc_sum_s[PHASE_W-1:0];
      sq_o   <= acc_sum_s[PHASE_W-1];
      sq90_o <= acc_sum_s[PHASE_W-1] ^ acc_sum_s[PHASE_W-2];
      cyc_o  <= acc_sum_s[PHASE_W];
    end
  end

  // Accumulate-and-dump decimator; the terminal sample goes straight into pitch_o
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dec_cnt_r   <= '0;
      sum_r       <= '0;
      pitch_o     <= '0;
      pitch_vld_o <= 1'b0;
    end else begin
      dec_cnt_r <= dec_cnt_r + DEC_W'(1);
      if (dec_tc_s) begin
        pitch_o     <= sum_nxt_s;
        sum_r       <= '0;
        pitch_vld_o <= 1'b1;
      end else begin
        sum_r       <= sum_nxt_s;
        pitch_vld_o <= 1'b0;
      end
    end
  end

endmodule
